// File: rtl/staging_unpacker.sv
// staging_unpacker: checks tags on {tag, payload} staged words and pairs good payloads into wide output words
module staging_unpacker #(
  parameter int TAG_WIDTH = 16,
  parameter int PAYLOAD_WIDTH = 16,
  parameter logic [TAG_WIDTH-1:0] VALID_TAG = TAG_WIDTH'(1),
  parameter int ERR_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [TAG_WIDTH+PAYLOAD_WIDTH-1:0] inWord,
  input  logic                             inValid,
  output logic                             inReady,
  output logic [2*PAYLOAD_WIDTH-1:0]       outWord,
  output logic                             outValid,
  input  logic                             outReady,
  output logic                             tagError,
  output logic [ERR_WIDTH-1:0]             errCount
);
  localparam logic [0:0] HI = 1'b0;
  localparam logic [0:0] LO = 1'b1;

  logic [0:0]               state;
  logic [PAYLOAD_WIDTH-1:0] hi_reg;
  logic [PAYLOAD_WIDTH-1:0] payload;
  logic                     tag_ok;
  logic                     accept;
  logic                     load;
  logic                     bad;

  assign payload = inWord[PAYLOAD_WIDTH-1:0];
  assign tag_ok  = inWord[TAG_WIDTH+PAYLOAD_WIDTH-1:PAYLOAD_WIDTH] == VALID_TAG;
  // a high half is always taken; a low half waits only while the output slot is stalled
  assign inReady = (state == HI) || !outValid || outReady;
  assign accept  = inValid && inReady;
  assign load    = accept && tag_ok && (state == LO);
  assign bad     = accept && !tag_ok;

  // pairing state and held high half; any low-slot accept, good or bad, returns to HI
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state  <= HI;
      hi_reg <= '0;
    end else if (accept) begin
      state  <= (state == HI && tag_ok) ? LO : HI;
      hi_reg <= (state == HI && tag_ok) ? payload : (bad ? '0 : hi_reg);
    end

  // output slot: a fresh load wins over consumption so back-to-back pairs leave no bubble
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      outWord  <= '0;
      outValid <= 1'b0;
    end else begin
      outWord  <= load ? {hi_reg, payload} : outWord;
      outValid <= load || (outValid && !outReady);
    end

  // registered drop pulse and saturating drop counter
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      tagError <= 1'b0;
      errCount <= '0;
    end else begin
      tagError <= bad;
      errCount <= (bad && !(&errCount)) ? errCount + 1'b1 : errCount;
    end
endmodule

// File: tb/tb_staging_unpacker.sv
// tb_staging_unpacker: directed and randomized checks of staging_unpacker against a pairing reference model
module tb_staging_unpacker;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] inWord;
  logic        inValid;
  logic        inReady;
  logic [31:0] outWord;
  logic        outValid;
  logic        outReady;
  logic        tagError;
  logic [7:0]  errCount;

  int checks = 0;
  int failures = 0;

  bit          m_hv;
  logic [15:0] m_hi;
  bit          m_ov;
  logic [31:0] m_ow;
  int          m_err;
  bit          m_te;
  bit          exp_rdy;
  logic        seen_rdy;

  staging_unpacker dut (
    .clk(clk), .reset(reset), .inWord(inWord), .inValid(inValid), .inReady(inReady),
    .outWord(outWord), .outValid(outValid), .outReady(outReady),
    .tagError(tagError), .errCount(errCount)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_hv = 0; m_hi = '0; m_ov = 0; m_ow = '0; m_err = 0; m_te = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; inValid = 1'b0; inWord = '0; outReady = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  // drive one cycle from a negedge, advance the model across the posedge, return at the next negedge
  task automatic cyc(input bit v, input logic [31:0] w, input bit r);
    bit acc, good, nv;
    inValid = v; inWord = w; outReady = r;
    #1;
    seen_rdy = inReady;
    exp_rdy = !m_hv || !m_ov || r;
    @(posedge clk);
    acc = v && exp_rdy;
    good = (w[31:16] == 16'h0001);
    m_te = acc && !good;
    nv = 0;
    if (acc && !good) begin
      if (m_err < 255) m_err++;
      m_hv = 0;
    end else if (acc && !m_hv) begin
      m_hv = 1; m_hi = w[15:0];
    end else if (acc) begin
      m_ow = {m_hi, w[15:0]}; nv = 1; m_hv = 0;
    end
    m_ov = nv || (m_ov && !r);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; inValid = 1'b0; inWord = '0; outReady = 1'b0;
    model_reset();
    @(negedge clk);
    checks++; if (outValid !== 1'b0) begin failures++; $display("FAIL reset_outValid got=%b want=0", outValid); end
    checks++; if (outWord !== 32'h0) begin failures++; $display("FAIL reset_outWord got=%h want=0", outWord); end
    checks++; if (errCount !== 8'h0) begin failures++; $display("FAIL reset_errCount got=%h want=0", errCount); end
    checks++; if (tagError !== 1'b0) begin failures++; $display("FAIL reset_tagError got=%b want=0", tagError); end
    checks++; if (inReady !== 1'b1) begin failures++; $display("FAIL reset_inReady got=%b want=1", inReady); end
    reset = 1'b1;
  endtask

  task automatic test_basic();
    do_reset();
    cyc(1, 32'h0001_1234, 1);
    checks++; if (outValid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%b want=0", outValid); end
    cyc(1, 32'h0001_ABCD, 1);
    checks++; if (outValid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b want=1", outValid); end
    checks++; if (outWord !== 32'h1234ABCD) begin failures++; $display("FAIL basic_word got=%h want=1234abcd", outWord); end
    cyc(0, 32'h0, 1);
    checks++; if (outValid !== 1'b0) begin failures++; $display("FAIL basic_one_cycle got=%b want=0", outValid); end
    checks++; if (errCount !== 8'd0) begin failures++; $display("FAIL basic_err got=%0d want=0", errCount); end
  endtask

  task automatic test_bad_tag();
    logic [31:0] seq [5] = '{32'h0002_1111, 32'h0001_2222, 32'h0005_3333, 32'h0001_4444, 32'h0001_5555};
    int pulses = 0, outs = 0;
    logic [31:0] last = '0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cyc(i < 5, i < 5 ? seq[i] : 32'h0, 1);
      if (tagError === 1'b1) pulses++;
      if (outValid === 1'b1) begin outs++; last = outWord; end
    end
    checks++; if (pulses != 2) begin failures++; $display("FAIL bad_pulses got=%0d want=2", pulses); end
    checks++; if (errCount !== 8'd2) begin failures++; $display("FAIL bad_errCount got=%0d want=2", errCount); end
    checks++; if (outs != 1) begin failures++; $display("FAIL bad_outputs got=%0d want=1", outs); end
    checks++; if (last !== 32'h44445555) begin failures++; $display("FAIL bad_word got=%h want=44445555", last); end
  endtask

  task automatic test_backpressure();
    do_reset();
    cyc(1, 32'h0001_1111, 0);
    cyc(1, 32'h0001_2222, 0);
    cyc(1, 32'h0001_3333, 0);
    checks++; if (seen_rdy !== 1'b1) begin failures++; $display("FAIL bp_hi_ready got=%b want=1", seen_rdy); end
    for (int i = 0; i < 2; i++) begin
      cyc(1, 32'h0001_4444, 0);
      checks++; if (seen_rdy !== 1'b0) begin failures++; $display("FAIL bp_lo_stall got=%b want=0", seen_rdy); end
      checks++; if (outWord !== 32'h11112222 || outValid !== 1'b1) begin failures++; $display("FAIL bp_hold got=%h/%b want=11112222/1", outWord, outValid); end
    end
    cyc(1, 32'h0001_4444, 1);
    checks++; if (seen_rdy !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b want=1", seen_rdy); end
    checks++; if (outValid !== 1'b1 || outWord !== 32'h33334444) begin failures++; $display("FAIL bp_simul_load got=%h/%b want=33334444/1", outWord, outValid); end
    cyc(0, 32'h0, 1);
    checks++; if (outValid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b want=0", outValid); end
  endtask

  task automatic test_saturation();
    int pulses = 0;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      cyc(1, {16'(($urandom % 1000) + 2), 16'($urandom)}, 1);
      if (tagError === 1'b1) pulses++;
      if (i == 254) begin
        checks++; if (errCount !== 8'hFF) begin failures++; $display("FAIL sat_reach got=%h want=ff", errCount); end
      end
    end
    cyc(0, 32'h0, 1);
    checks++; if (pulses != 300) begin failures++; $display("FAIL sat_pulses got=%0d want=300", pulses); end
    checks++; if (errCount !== 8'hFF) begin failures++; $display("FAIL sat_hold got=%h want=ff", errCount); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cyc(1, 32'h0001_0101, 0);
    cyc(1, 32'h0001_0202, 0);
    cyc(1, 32'h0001_AAAA, 0);
    #2 reset = 1'b0;
    #1;
    checks++; if (outValid !== 1'b0 || outWord !== 32'h0) begin failures++; $display("FAIL mid_reset_out got=%h/%b want=0/0", outWord, outValid); end
    checks++; if (inReady !== 1'b1) begin failures++; $display("FAIL mid_reset_ready got=%b want=1", inReady); end
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    cyc(1, 32'h0001_BBBB, 1);
    cyc(1, 32'h0001_CCCC, 1);
    checks++; if (outValid !== 1'b1 || outWord !== 32'hBBBBCCCC) begin failures++; $display("FAIL mid_reset_next got=%h/%b want=bbbbcccc/1", outWord, outValid); end
  endtask

  task automatic test_random();
    int bad_rdy = 0, bad_out = 0, bad_err = 0;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      logic [15:0] t;
      t = ($urandom % 4 == 0) ? 16'(($urandom % 7) + 2) : 16'h0001;
      cyc($urandom % 4 != 0, {t, 16'($urandom)}, $urandom % 3 != 0);
      checks++; if (seen_rdy !== exp_rdy) begin failures++; if (bad_rdy++ < 5) $display("FAIL rnd_inReady cyc=%0d got=%b want=%b", i, seen_rdy, exp_rdy); end
      checks++; if (outValid !== m_ov || outWord !== m_ow) begin failures++; if (bad_out++ < 5) $display("FAIL rnd_out cyc=%0d got=%h/%b want=%h/%b", i, outWord, outValid, m_ow, m_ov); end
      checks++; if (tagError !== m_te || errCount !== 8'(m_err)) begin failures++; if (bad_err++ < 5) $display("FAIL rnd_err cyc=%0d got=%b/%0d want=%b/%0d", i, tagError, errCount, m_te, m_err); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_tag();
    test_backpressure();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/staging_unpacker.md
# staging_unpacker

Receive-side counterpart of the staging packer. Consumes a stream of 32-bit staged words, each `{tag[15:0], payload[15:0]}`, and checks each tag against the expected value. Consecutive valid payloads are paired (high half first, then low half) into 32-bit words on a valid/ready output. The block sits between the staged link and any 32-bit consumer; words with a bad tag are dropped, flagged and counted.

## Interface
- `TAG_WIDTH`, default 16: width of the tag field in bits.
- `PAYLOAD_WIDTH`, default 16: width of the payload field in bits.
- `VALID_TAG`, default 16'd1: the tag value that marks a payload word.
- `ERR_WIDTH`, default 8: width of the error counter in bits.
- `clk` input, 1 bit: single clock; all state updates on posedge.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `inWord` input, TAG_WIDTH+PAYLOAD_WIDTH bits: staged word, `{tag, payload}`.
- `inValid` input, 1 bit: `inWord` is valid.
- `inReady` output, 1 bit: the unpacker can accept a word this cycle.
- `outWord` output, 2*PAYLOAD_WIDTH bits: reassembled word, `{hiPayload, loPayload}`.
- `outValid` output, 1 bit: `outWord` holds an unconsumed word.
- `outReady` input, 1 bit: the consumer takes `outWord` this cycle.
- `tagError` output, 1 bit: one-cycle pulse when a word with a bad tag is dropped.
- `errCount` output, ERR_WIDTH bits: saturating count of dropped words.

## Operation
- An input word is accepted on a posedge where `inValid && inReady`.
- The tag is `inWord[TAG_WIDTH+PAYLOAD_WIDTH-1:PAYLOAD_WIDTH]`; the payload is `inWord[PAYLOAD_WIDTH-1:0]`.
- The state machine has two states, HI and LO. Reset state is HI.
- HI:
  - `inReady` = 1.
  - Accept with good tag: store the payload in the hi register, then go to LO.
  - Accept with bad tag: drop the word, pulse `tagError`, increment `errCount`, stay in HI.
- LO:
  - `inReady` = `!outValid || outReady`.
  - Accept with good tag: `outWord` <= `{hiReg, payload}`, `outValid` <= 1, go to HI.
  - Accept with bad tag: drop the word, pulse `tagError`, increment `errCount`, discard `hiReg`, go to HI. `outWord` and `outValid` are unchanged apart from normal consumption.
- Output register:
  - `outValid` clears on `outValid && outReady` unless a new word loads in the same cycle.
  - When a new word loads, it overrides the clear and `outValid` stays 1.
  - `outWord` is stable while `outValid && !outReady`.
- A payload of 0 is legal data and has no special meaning. A `{VALID_TAG, 16'd0}` word is paired like any other.
- `errCount` saturates at all-ones and never wraps.
- `tagError` is high exactly in the cycle after the bad accept, i.e. it is registered.

## Timing
- Reset (`reset` low, asynchronous) forces:
  - state = HI, `hiReg` = 0
  - `outWord` = 0, `outValid` = 0
  - `tagError` = 0, `errCount` = 0
  - Consequently `inReady` = 1 while in reset (HI state).
- Reset takes effect immediately, mid-frame or mid-handshake. A partial pair is lost and the pending output is discarded.
- Release of `reset` is seen at the next posedge.
- Latency: `outValid` rises one cycle after the LO-half accept edge.
- Throughput: one output per two accepted inputs. With `outReady` held high, back-to-back pairs sustain one input per cycle.
- Backpressure: a good HI word is always accepted. A LO word stalls (`inReady` = 0) only while `outValid && !outReady`.
- `inReady` is combinational from state, `outValid` and `outReady`. There is no combinational path from `inValid` or `inWord`.
- Simultaneous events:
  - LO accept and output consume in the same cycle: the new word replaces the old one and `outValid` stays 1.
  - Bad tag in LO while the output is stalled: the word is still accepted (dropped) only if `inReady` = 1. Otherwise it waits.

## Test plan
- Basic pair:
  - Stimulus: reset low then high; send `0x0001_1234`, then `0x0001_ABCD`, with `outReady` = 1.
  - Response: `outWord` = `0x1234ABCD`, `outValid` high for one cycle, asserted on the cycle after the second accept; `errCount` = 0.
- Bad tag in HI and in LO:
  - Stimulus: send `0x0002_1111`, then `0x0001_2222`, then `0x0005_3333`, then `0x0001_4444`, then `0x0001_5555`.
  - Response: two `tagError` pulses; `errCount` = 2; exactly one output, `0x44445555`.
- Backpressure:
  - Stimulus: hold `outReady` = 0 after the first pair completes, then present a second pair.
  - Response: the HI half is accepted; `inReady` = 0 for the LO half; `outWord` is held until `outReady` = 1, after which the second pair completes as `{hi2, lo2}`.
- Simultaneous consume and load:
  - Stimulus: `outValid` = 1 and `outReady` = 1 on the same edge as a good LO accept.
  - Response: `outValid` stays 1 and `outWord` updates to the new pair with no bubble.
- Saturation:
  - Stimulus: 300 bad-tag words.
  - Response: `errCount` = `0xFF` (default ERR_WIDTH = 8) and holds there; `tagError` pulses 300 times.
- Reset mid-operation:
  - Stimulus: accept HI `0x0001_AAAA`, assert `reset` low between clock edges, release it, then send `0x0001_BBBB` and `0x0001_CCCC`.
  - Response: outputs clear immediately when `reset` goes low; the next output is `0xBBBBCCCC`.
